u_rx_fifo: RTL and testbench
============================

U_RX_FIFO -- requirements
Module: u_rx_fifo

Interface
REQ-001 The module SHALL have parameter width, default 8, as the data word width in bits.
REQ-002 The module SHALL have parameter depth, default 16, as the number of storage entries; it SHALL be a power of two and at least 2.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port rx_data, input, width bits: received word from the UART receiver's data_out.
REQ-006 The module SHALL have port rx_data_ready, input, 1 bit: receiver completion flag; it is a level that may stay high for many clk cycles.
REQ-007 The module SHALL have port rd_en, input, 1 bit: consumer read request.
REQ-008 The module SHALL have port rd_data, output, width bits: the word that was read.
REQ-009 The module SHALL have port rd_valid, output, 1 bit: one-cycle pulse marking rd_data valid.
REQ-010 The module SHALL have port empty, output, 1 bit: high when the stored count is 0.
REQ-011 The module SHALL have port full, output, 1 bit: high when the stored count equals depth.
REQ-012 The module SHALL have port count, output, $clog2(depth)+1 bits: number of stored words.
REQ-013 The module SHALL have port overflow, output, 1 bit: sticky flag set when a word has been dropped.
REQ-014 The module SHALL have port ovf_clr, input, 1 bit: clears overflow.

Function
REQ-015 A register rdy_q SHALL capture rx_data_ready every clk; a write event SHALL occur only when rx_data_ready=1 and rdy_q=0, i.e. one write per rising edge of the flag.
REQ-016 On a write event with full=0, rx_data SHALL be stored at wr_ptr, wr_ptr SHALL increment modulo depth, and count SHALL increment.
REQ-017 On a write event with full=1 and no accepted read in the same cycle, the word SHALL be dropped, overflow SHALL be set to 1, and pointers and count SHALL remain unchanged.
REQ-018 A read SHALL be accepted when rd_en=1 and empty=0.
REQ-019 When a read is accepted, rd_data SHALL present mem[rd_ptr] on the next clk, with rd_valid=1 for exactly that one cycle; rd_ptr SHALL increment modulo depth and count SHALL decrement, giving 1-cycle read latency.
REQ-020 rd_en while empty=1 SHALL be ignored: rd_valid SHALL be 0, rd_data SHALL hold its value, and no flag SHALL change.
REQ-021 rd_data SHALL hold its last value while rd_valid=0.
REQ-022 When a write event and an accepted read occur in the same cycle with full=1, both SHALL complete, count SHALL stay at depth, and no overflow SHALL occur.
REQ-023 When a write event and an accepted read occur in the same cycle with 0<count<depth, both SHALL complete and count SHALL be unchanged.
REQ-024 When a write event and rd_en=1 occur in the same cycle with empty=1, the write SHALL complete, the read SHALL be ignored, and count SHALL become 1.
REQ-025 empty, full and count SHALL be registered and consistent with each other in every cycle.
REQ-026 Pointers SHALL wrap from depth-1 to 0 with no loss or duplication of data.
REQ-027 ovf_clr=1 SHALL clear overflow on the next clk; if a drop occurs in the same cycle, set SHALL take priority and overflow SHALL read 1.

Reset
REQ-028 While rst=1 on a clk edge, wr_ptr, rd_ptr, count, overflow, rd_valid and rd_data SHALL go to 0, empty SHALL go to 1, full SHALL go to 0, and rdy_q SHALL go to 1.
REQ-029 Because rdy_q resets to 1, a rx_data_ready level already high at reset release SHALL NOT produce a write.
REQ-030 rst asserted mid-operation SHALL discard all stored words; memory contents need not be cleared.
REQ-031 rst SHALL take priority over all write, read and clear activity in the same cycle.

Verification
REQ-032 The bench SHALL cover: rx_data=0xA5 with rx_data_ready held high 20 cycles, then rd_en for 1 cycle -> exactly one word stored (count=1); rd_data=0xA5 with rd_valid=1 one cycle after rd_en; empty=1.
REQ-033 The bench SHALL cover: 16 write edges with data 0x00..0x0F, then a 17th with 0xFF -> full=1, overflow=1, count=16; 16 reads return 0x00..0x0F in order.
REQ-034 The bench SHALL cover: full FIFO, then a write edge (0x55) and rd_en in the same cycle -> count=16, overflow=0; the read returns the oldest word and 0x55 is read last.
REQ-035 The bench SHALL cover: empty FIFO, then a write edge (0x3C) and rd_en in the same cycle -> rd_valid=0, count=1; the next read returns 0x3C.
REQ-036 The bench SHALL cover: rx_data_ready=1 during rst, then rst released with rx_data_ready still high -> no write (count=0); a later low-to-high edge writes one word.
REQ-037 The bench SHALL cover: a drop in the same cycle as ovf_clr=1 -> overflow=1; ovf_clr alone on a later cycle -> overflow=0.

Source files
------------

// File: rtl/u_rx_fifo.sv
// u_rx_fifo: receive FIFO sitting behind a UART receiver.
// A write is taken once per rising edge of rx_data_ready, reads have one
// cycle of latency, and a sticky overflow flag records dropped words.
module u_rx_fifo #(
    parameter int unsigned width = 8,
    parameter int unsigned depth = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [width-1:0]           rx_data,
    input  logic                       rx_data_ready,
    input  logic                       rd_en,
    output logic [width-1:0]           rd_data,
    output logic                       rd_valid,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(depth):0]     count,
    output logic                       overflow,
    input  logic                       ovf_clr
);

    localparam int unsigned AW = $clog2(depth);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(depth);

    logic [width-1:0] mem [depth];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             empty_q, full_q;
    logic             overflow_q, overflow_d;
    logic             rdy_q;
    logic [width-1:0] rd_data_q;
    logic             rd_valid_q;

    logic             wr_ev;
    logic             rd_acc;
    logic             wr_acc;
    logic             drop;

    // Edge detect, accept/drop decisions and next-state for pointers, count, overflow
    always_comb begin
        wr_ev  = rx_data_ready & ~rdy_q;
        rd_acc = rd_en & ~empty_q;
        // A full FIFO can still take a word when a read frees a slot this cycle
        wr_acc = wr_ev & (~full_q | rd_acc);
        drop   = wr_ev & full_q & ~rd_acc;

        wr_ptr_d = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;

        count_d = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    // Control state, flags and read output register
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            rdy_q      <= 1'b1;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= (count_d == '0);
            full_q     <= (count_d == DEPTH_C);
            overflow_q <= overflow_d;
            rdy_q      <= rx_data_ready;
            rd_valid_q <= rd_acc;
            if (rd_acc) begin
                rd_data_q <= mem[rd_ptr_q];
            end
        end
    end

    // Storage array; left uncleared by reset, pointers define what is valid
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr_q] <= rx_data;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign empty    = empty_q;
    assign full     = full_q;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_u_rx_fifo.sv
// Directed testbench for u_rx_fifo (width=8, depth=16).
module tb_u_rx_fifo;

    localparam int unsigned W  = 8;
    localparam int unsigned D  = 16;
    localparam int unsigned CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  rx_data;
    logic          rx_data_ready;
    logic          rd_en;
    logic [W-1:0]  rd_data;
    logic          rd_valid;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          overflow;
    logic          ovf_clr;

    int checks   = 0;
    int failures = 0;

    u_rx_fifo #(.width(W), .depth(D)) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data       (rx_data),
        .rx_data_ready (rx_data_ready),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .empty         (empty),
        .full          (full),
        .count         (count),
        .overflow      (overflow),
        .ovf_clr       (ovf_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset, then one idle cycle with rx_data_ready low so rdy_q is 0
    task automatic do_reset();
        rst = 1'b1; rx_data_ready = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0; rx_data = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic write_edge(input logic [W-1:0] d);
        rx_data = d; rx_data_ready = 1'b1;
        tick();
        rx_data_ready = 1'b0;
        tick();
    endtask

    task automatic read_one(input string name, input logic [W-1:0] exp);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++;
        if (rd_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s rd_valid: got %b expected 1", name, rd_valid);
        end
        checks++;
        if (rd_data !== exp) begin
            failures++;
            $display("FAIL %s rd_data: got %h expected %h", name, rd_data, exp);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({empty, full, overflow, rd_valid} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_flags: got e=%b f=%b o=%b v=%b expected e=1 f=0 o=0 v=0",
                     empty, full, overflow, rd_valid);
        end
        checks++;
        if (count !== 5'd0) begin
            failures++;
            $display("FAIL reset_count: got %0d expected 0", count);
        end
        checks++;
        if (rd_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_rd_data: got %h expected 00", rd_data);
        end
    endtask

    task automatic test_level_hold();
        do_reset();
        rx_data = 8'hA5; rx_data_ready = 1'b1;
        repeat (20) tick();
        rx_data_ready = 1'b0;
        tick();
        checks++;
        if (count !== 5'd1 || empty !== 1'b0) begin
            failures++;
            $display("FAIL level_count: got count=%0d empty=%b expected count=1 empty=0", count, empty);
        end
        read_one("level_read", 8'hA5);
        checks++;
        if (empty !== 1'b1 || count !== 5'd0) begin
            failures++;
            $display("FAIL level_empty: got empty=%b count=%0d expected empty=1 count=0", empty, count);
        end
        tick();
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 8'hA5) begin
            failures++;
            $display("FAIL level_hold: got v=%b d=%h expected v=0 d=a5", rd_valid, rd_data);
        end
    endtask

    task automatic test_fill_overflow();
        do_reset();
        for (int i = 0; i < 16; i++) write_edge(8'(i));
        checks++;
        if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL fill_full: got f=%b c=%0d o=%b expected f=1 c=16 o=0", full, count, overflow);
        end
        write_edge(8'hFF);
        checks++;
        if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL fill_drop: got f=%b c=%0d o=%b expected f=1 c=16 o=1", full, count, overflow);
        end
        for (int i = 0; i < 16; i++) begin
            read_one("fill_read", 8'(i));
            checks++;
            if (count !== 5'(15 - i)) begin
                failures++;
                $display("FAIL fill_read_count: got %0d expected %0d", count, 15 - i);
            end
        end
        checks++;
        if (empty !== 1'b1 || full !== 1'b0) begin
            failures++;
            $display("FAIL fill_drained: got e=%b f=%b expected e=1 f=0", empty, full);
        end
        // Read on empty: ignored, data held, overflow still sticky
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 8'h0F || count !== 5'd0 || empty !== 1'b1 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL empty_read: got v=%b d=%h c=%0d e=%b o=%b expected v=0 d=0f c=0 e=1 o=1",
                     rd_valid, rd_data, count, empty, overflow);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        write_edge(8'h01);
        write_edge(8'h02);
        rx_data = 8'h03; rx_data_ready = 1'b1; rd_en = 1'b1;
        tick();
        rx_data_ready = 1'b0; rd_en = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h01 || count !== 5'd2) begin
            failures++;
            $display("FAIL mid_simul: got v=%b d=%h c=%0d expected v=1 d=01 c=2", rd_valid, rd_data, count);
        end
        tick();
        read_one("mid_read2", 8'h02);
        read_one("mid_read3", 8'h03);
        checks++;
        if (empty !== 1'b1) begin
            failures++;
            $display("FAIL mid_empty: got %b expected 1", empty);
        end
    endtask

    task automatic test_full_simul();
        do_reset();
        for (int i = 0; i < 16; i++) write_edge(8'(8'h10 + i));
        rx_data = 8'h55; rx_data_ready = 1'b1; rd_en = 1'b1;
        tick();
        rx_data_ready = 1'b0; rd_en = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h10) begin
            failures++;
            $display("FAIL full_simul_read: got v=%b d=%h expected v=1 d=10", rd_valid, rd_data);
        end
        checks++;
        if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL full_simul_flags: got c=%0d f=%b o=%b expected c=16 f=1 o=0", count, full, overflow);
        end
        tick();
        for (int i = 1; i < 16; i++) read_one("full_simul_drain", 8'(8'h10 + i));
        read_one("full_simul_last", 8'h55);
        checks++;
        if (empty !== 1'b1 || count !== 5'd0) begin
            failures++;
            $display("FAIL full_simul_empty: got e=%b c=%0d expected e=1 c=0", empty, count);
        end
    endtask

    task automatic test_empty_simul();
        do_reset();
        rx_data = 8'h3C; rx_data_ready = 1'b1; rd_en = 1'b1;
        tick();
        rx_data_ready = 1'b0; rd_en = 1'b0;
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 8'h00 || count !== 5'd1 || empty !== 1'b0) begin
            failures++;
            $display("FAIL empty_simul: got v=%b d=%h c=%0d e=%b expected v=0 d=00 c=1 e=0",
                     rd_valid, rd_data, count, empty);
        end
        tick();
        read_one("empty_simul_read", 8'h3C);
    endtask

    task automatic test_reset_ready_high();
        do_reset();
        write_edge(8'h77);
        rst = 1'b1; rx_data = 8'h99; rx_data_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (count !== 5'd0 || empty !== 1'b1) begin
            failures++;
            $display("FAIL rst_ready_high: got c=%0d e=%b expected c=0 e=1", count, empty);
        end
        rx_data_ready = 1'b0;
        tick();
        rx_data = 8'h42; rx_data_ready = 1'b1;
        tick();
        checks++;
        if (count !== 5'd1) begin
            failures++;
            $display("FAIL rst_later_edge: got c=%0d expected 1", count);
        end
        rx_data_ready = 1'b0;
        tick();
        read_one("rst_later_read", 8'h42);
    endtask

    task automatic test_ovf_clr();
        do_reset();
        for (int i = 0; i < 16; i++) write_edge(8'(8'h20 + i));
        write_edge(8'hE1);
        rx_data = 8'hE2; rx_data_ready = 1'b1; ovf_clr = 1'b1;
        tick();
        rx_data_ready = 1'b0; ovf_clr = 1'b0;
        checks++;
        if (overflow !== 1'b1 || count !== 5'd16) begin
            failures++;
            $display("FAIL ovf_set_priority: got o=%b c=%0d expected o=1 c=16", overflow, count);
        end
        tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0 || count !== 5'd16) begin
            failures++;
            $display("FAIL ovf_clear: got o=%b c=%0d expected o=0 c=16", overflow, count);
        end
        read_one("ovf_oldest", 8'h20);
    endtask

    initial begin
        rst = 1'b1; rx_data = '0; rx_data_ready = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0;
        test_reset();
        test_level_hold();
        test_fill_overflow();
        test_back_to_back();
        test_full_simul();
        test_empty_simul();
        test_reset_ready_high();
        test_ovf_clr();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
